// File: rtl/double_ge_pipe.sv
// Three-stage pipelined IEEE-754 binary64 "a >= b" comparator with valid/ready
// handshaking on both sides; NaN operands yield an unordered result.
module double_ge_pipe #(
  parameter logic NAN_RESULT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_z,
  output logic        out_unordered,
  output logic        out_valid,
  input  logic        out_ready
);

  logic        s1_valid;
  logic [62:0] s1_mag_a;
  logic [62:0] s1_mag_b;
  logic        s1_sign_a;
  logic        s1_sign_b;
  logic        s1_nan;
  logic        s1_both_zero;

  logic        s2_valid;
  logic        s2_z;
  logic        s2_unord;

  logic        s3_valid;
  logic        s3_z;
  logic        s3_unord;

  logic        s1_adv;
  logic        s2_adv;
  logic        s3_adv;

  logic        a_nan;
  logic        b_nan;
  logic        both_zero;
  logic        cmp_z;

  // Each stage moves when it is empty or the stage downstream is moving.
  assign s3_adv   = !s3_valid || out_ready;
  assign s2_adv   = !s2_valid || s3_adv;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign a_nan     = (in_a[62:52] == 11'h7FF) && (in_a[51:0] != 52'd0);
  assign b_nan     = (in_b[62:52] == 11'h7FF) && (in_b[51:0] != 52'd0);
  assign both_zero = (in_a[62:0] == 63'd0) && (in_b[62:0] == 63'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_mag_a     <= '0;
      s1_mag_b     <= '0;
      s1_sign_a    <= 1'b0;
      s1_sign_b    <= 1'b0;
      s1_nan       <= 1'b0;
      s1_both_zero <= 1'b0;
    end else if (s1_adv) begin
      s1_valid     <= in_valid;
      s1_mag_a     <= in_a[62:0];
      s1_mag_b     <= in_b[62:0];
      s1_sign_a    <= in_a[63];
      s1_sign_b    <= in_b[63];
      s1_nan       <= a_nan || b_nan;
      s1_both_zero <= both_zero;
    end
  end

  // Sign-magnitude ordering: negative operands compare with reversed magnitude.
  always_comb begin
    cmp_z = 1'b0;
    if (s1_nan) begin
      cmp_z = NAN_RESULT;
    end else if (s1_both_zero) begin
      cmp_z = 1'b1;
    end else if (s1_sign_a != s1_sign_b) begin
      cmp_z = !s1_sign_a;
    end else if (!s1_sign_a) begin
      cmp_z = (s1_mag_a >= s1_mag_b);
    end else begin
      cmp_z = (s1_mag_a <= s1_mag_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_z     <= 1'b0;
      s2_unord <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      s2_z     <= cmp_z;
      s2_unord <= s1_nan;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_z     <= 1'b0;
      s3_unord <= 1'b0;
    end else if (s3_adv) begin
      s3_valid <= s2_valid;
      s3_z     <= s2_z;
      s3_unord <= s2_unord;
    end
  end

  assign out_valid     = s3_valid;
  assign out_z         = s3_z;
  assign out_unordered = s3_unord;

endmodule
